// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control unit: Moore FSM sequencing fetch, decode and
// per-class execute/writeback states. Branch PCLoad additionally follows zero.
module mc_controller (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opc,
   input  logic [5:0] func,
   input  logic       zero,
   output logic       PCLoad,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       JalSig1,
   output logic       MemToReg,
   output logic       JalSig2,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOperation,
   output logic [1:0] PCSrc,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB   = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_JAL    = 4'd10, S_JR    = 4'd11,
      S_IEXEC  = 4'd12, S_IWB    = 4'd13
   } state_t;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_t r_state;

   logic w_func_alu;
   logic w_is_rtype;
   logic w_is_jr;
   logic [2:0] w_rtype_op;

   assign w_func_alu = (func == FN_ADD) || (func == FN_SUB) || (func == FN_AND) ||
                       (func == FN_OR)  || (func == FN_SLT);
   assign w_is_rtype = (opc == OP_RTYPE) && w_func_alu;
   assign w_is_jr    = (opc == OP_RTYPE) && (func == FN_JR);

   always_comb begin
      w_rtype_op = ALU_ADD;
      case (func)
         FN_SUB:  w_rtype_op = ALU_SUB;
         FN_AND:  w_rtype_op = ALU_AND;
         FN_OR:   w_rtype_op = ALU_OR;
         FN_SLT:  w_rtype_op = ALU_SLT;
         default: w_rtype_op = ALU_ADD;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
      end else begin
         case (r_state)
            S_FETCH:  r_state <= S_DECODE;
            S_DECODE: begin
               if (w_is_jr)                               r_state <= S_JR;
               else if (w_is_rtype)                       r_state <= S_REXEC;
               else if (opc == OP_LW || opc == OP_SW)     r_state <= S_MEMADR;
               else if (opc == OP_BEQ || opc == OP_BNE)   r_state <= S_BRANCH;
               else if (opc == OP_J)                      r_state <= S_JUMP;
               else if (opc == OP_JAL)                    r_state <= S_JAL;
               else if (opc == OP_ADDI || opc == OP_SLTI) r_state <= S_IEXEC;
               else                                       r_state <= S_FETCH;
            end
            S_MEMADR: r_state <= (opc == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  r_state <= S_MEMWB;
            S_REXEC:  r_state <= S_RWB;
            S_IEXEC:  r_state <= S_IWB;
            default:  r_state <= S_FETCH;
         endcase
      end
   end

   assign state = r_state;

   // Outputs decode the registered state; gating with rst keeps every strobe
   // low during reset even though the state code already reads FETCH.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      PCLoad       = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      JalSig1      = 1'b0;
      MemToReg     = 1'b0;
      JalSig2      = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOperation = ALU_AND;
      PCSrc        = 2'b00;
      if (rst) begin
         case (r_state)
            S_FETCH: begin
               MemRead      = 1'b1;
               IRWrite      = 1'b1;
               ALUSrcB      = 2'b01;
               ALUOperation = ALU_ADD;
               PCLoad       = 1'b1;
            end
            S_DECODE: begin
               ALUSrcB      = 2'b11;
               ALUOperation = ALU_ADD;
            end
            S_MEMADR: begin
               ALUSrcA      = 1'b1;
               ALUSrcB      = 2'b10;
               ALUOperation = ALU_ADD;
            end
            S_MEMRD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
            end
            S_MEMWB:  RegWrite = 1'b1;
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = 1'b1;
            end
            S_REXEC: begin
               ALUSrcA      = 1'b1;
               ALUOperation = w_rtype_op;
            end
            S_RWB: begin
               RegDst   = 1'b1;
               MemToReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA      = 1'b1;
               ALUOperation = ALU_SUB;
               PCSrc        = 2'b10;
               PCLoad       = (opc == OP_BEQ) ? zero : ~zero;
            end
            S_JUMP: begin
               PCSrc  = 2'b01;
               PCLoad = 1'b1;
            end
            S_JAL: begin
               JalSig1  = 1'b1;
               JalSig2  = 1'b1;
               RegWrite = 1'b1;
               PCSrc    = 2'b01;
               PCLoad   = 1'b1;
            end
            S_JR: begin
               PCSrc  = 2'b11;
               PCLoad = 1'b1;
            end
            S_IEXEC: begin
               ALUSrcA      = 1'b1;
               ALUSrcB      = 2'b10;
               ALUOperation = (opc == OP_ADDI) ? ALU_ADD : ALU_SLT;
            end
            S_IWB: begin
               MemToReg = 1'b1;
               RegWrite = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: an instruction-class model predicts the
// state walk and control word per cycle; directed cases cover reset handling.
module tb_mc_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opc;
   logic [5:0] func;
   logic       zero;
   logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
   logic       MemToReg, JalSig2, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOperation;
   logic [3:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   mc_controller dut (
      .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
      .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1), .MemToReg(MemToReg),
      .JalSig2(JalSig2), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOperation(ALUOperation), .PCSrc(PCSrc), .state(state)
   );

   always #5 clk = ~clk;

   typedef enum {C_LW, C_SW, C_R, C_BR, C_J, C_JAL, C_JR, C_I, C_BAD} icls_e;

   typedef struct packed {
      logic       pc_load;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       jal1;
      logic       mem_to_reg;
      logic       jal2;
      logic       reg_write;
      logic       src_a;
      logic [1:0] src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic icls_e classify(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'b000000: begin
            if (f == 6'b001000) return C_JR;
            if (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                f == 6'b100101 || f == 6'b101010) return C_R;
            return C_BAD;
         end
         6'b100011:            return C_LW;
         6'b101011:            return C_SW;
         6'b000100, 6'b000101: return C_BR;
         6'b000010:            return C_J;
         6'b000011:            return C_JAL;
         6'b001000, 6'b001010: return C_I;
         default:              return C_BAD;
      endcase
   endfunction

   // Cycles per instruction including FETCH.
   function automatic int seq_len(input icls_e c);
      case (c)
         C_LW:                return 5;
         C_SW, C_R, C_I:      return 4;
         C_BAD:               return 2;
         default:             return 3;
      endcase
   endfunction

   function automatic int exp_state(input icls_e c, input int k);
      if (k == 0) return 0;
      if (k == 1) return 1;
      if (k == 2) begin
         case (c)
            C_LW, C_SW: return 2;
            C_R:        return 6;
            C_BR:       return 8;
            C_J:        return 9;
            C_JAL:      return 10;
            C_JR:       return 11;
            C_I:        return 12;
            default:    return 15;
         endcase
      end
      if (k == 3) begin
         case (c)
            C_LW:    return 3;
            C_SW:    return 5;
            C_R:     return 7;
            C_I:     return 13;
            default: return 15;
         endcase
      end
      return 4;
   endfunction

   function automatic ctrl_t exp_ctrl(input int st, input logic [5:0] o,
                                      input logic [5:0] f, input logic z);
      ctrl_t c = '0;
      case (st)
         0: begin
            c.mem_read = 1; c.ir_write = 1; c.src_b = 2'b01; c.alu_op = 3'b010; c.pc_load = 1;
         end
         1: begin c.src_b = 2'b11; c.alu_op = 3'b010; end
         2: begin c.src_a = 1; c.src_b = 2'b10; c.alu_op = 3'b010; end
         3: begin c.iord = 1; c.mem_read = 1; end
         4: c.reg_write = 1;
         5: begin c.iord = 1; c.mem_write = 1; end
         6: begin
            c.src_a = 1;
            case (f)
               6'b100010: c.alu_op = 3'b110;
               6'b100100: c.alu_op = 3'b000;
               6'b100101: c.alu_op = 3'b001;
               6'b101010: c.alu_op = 3'b111;
               default:   c.alu_op = 3'b010;
            endcase
         end
         7: begin c.reg_dst = 1; c.mem_to_reg = 1; c.reg_write = 1; end
         8: begin
            c.src_a = 1; c.alu_op = 3'b110; c.pc_src = 2'b10;
            c.pc_load = (o == 6'b000100) ? z : !z;
         end
         9:  begin c.pc_src = 2'b01; c.pc_load = 1; end
         10: begin c.jal1 = 1; c.jal2 = 1; c.reg_write = 1; c.pc_src = 2'b01; c.pc_load = 1; end
         11: begin c.pc_src = 2'b11; c.pc_load = 1; end
         12: begin c.src_a = 1; c.src_b = 2'b10; c.alu_op = (o == 6'b001000) ? 3'b010 : 3'b111; end
         13: begin c.mem_to_reg = 1; c.reg_write = 1; end
         default: ;
      endcase
      return c;
   endfunction

   function automatic logic [31:0] obs_ctrl();
      return {14'd0, PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1,
              MemToReg, JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc};
   endfunction

   task automatic check_cycle(input string name, input int st);
      check({name, "_state"}, {28'd0, state}, st);
      check({name, "_ctrl"}, obs_ctrl(), {14'd0, exp_ctrl(st, opc, func, zero)});
      check({name, "_rd_wr_excl"}, {31'd0, MemRead & MemWrite}, 0);
      check({name, "_rw_wr_excl"}, {31'd0, RegWrite & MemWrite}, 0);
   endtask

   // Entry: just after the edge that entered FETCH. Exit: the same point of
   // the following instruction.
   task automatic run_instr(input string name, input logic [5:0] o,
                            input logic [5:0] f, input logic z);
      icls_e c;
      opc = o; func = f; zero = z;
      c = classify(o, f);
      for (int k = 0; k < seq_len(c); k++) begin
         @(negedge clk);
         check_cycle(name, exp_state(c, k));
         @(posedge clk);
         #1;
      end
      check({name, "_ret_fetch"}, {28'd0, state}, 0);
   endtask

   task automatic reset_during_sw();
      opc = 6'b101011; func = 6'd0; zero = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_cycle("rst_sw", exp_state(C_SW, k));
         if (k < 3) begin
            @(posedge clk);
            #1;
         end
      end
      #1 rst = 1'b0;
      #1;
      check("rst_async_state", {28'd0, state}, 0);
      check("rst_async_memwrite", {31'd0, MemWrite}, 0);
      check("rst_async_ctrl", obs_ctrl(), 0);
      @(posedge clk);
      #1;
      check("rst_hold_state", {28'd0, state}, 0);
      rst = 1'b1;
      #1;
      check("rst_release_fetch", obs_ctrl(), {14'd0, exp_ctrl(0, opc, func, zero)});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] o, f;
      logic [5:0] rfn [5];
      rfn[0] = 6'b100000; rfn[1] = 6'b100010; rfn[2] = 6'b100100;
      rfn[3] = 6'b100101; rfn[4] = 6'b101010;

      rst = 1'b0; opc = 6'b100011; func = 6'd0; zero = 1'b0;
      #2;
      check("reset_state", {28'd0, state}, 0);
      check("reset_ctrl", obs_ctrl(), 0);
      @(posedge clk);
      #1;
      check("reset_edge_state", {28'd0, state}, 0);
      check("reset_edge_ctrl", obs_ctrl(), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      run_instr("lw",    6'b100011, 6'b000000, 1'b0);
      run_instr("sub",   6'b000000, 6'b100010, 1'b0);
      run_instr("beq_z", 6'b000100, 6'b000000, 1'b1);
      run_instr("bne_z", 6'b000101, 6'b000000, 1'b1);
      run_instr("beq_n", 6'b000100, 6'b000000, 1'b0);
      run_instr("jal",   6'b000011, 6'b000000, 1'b0);
      run_instr("jr",    6'b000000, 6'b001000, 1'b0);
      run_instr("undef", 6'b111111, 6'b111111, 1'b0);
      run_instr("sw",    6'b101011, 6'b000000, 1'b0);
      run_instr("slti",  6'b001010, 6'b000000, 1'b0);
      reset_during_sw();
      run_instr("post_rst_addi", 6'b001000, 6'b000000, 1'b1);

      for (int i = 0; i < 300; i++) begin
         f = 6'($urandom);
         case ($urandom_range(0, 9))
            0: o = 6'b100011;
            1: o = 6'b101011;
            2: begin o = 6'b000000; f = rfn[$urandom_range(0, 4)]; end
            3: o = 6'b000100;
            4: o = 6'b000101;
            5: o = 6'b000010;
            6: o = 6'b000011;
            7: begin o = 6'b000000; f = 6'b001000; end
            8: o = ($urandom_range(0, 1) == 0) ? 6'b001000 : 6'b001010;
            default: o = 6'($urandom);
         endcase
         run_instr("rand", o, f, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
